// File: rtl/deser_1to8.sv
// Serial-to-parallel receiver: collects 8 qualified bits into a shadow word
// and presents the completed word on out0..out7 with a valid/ready handshake.
module deser_1to8 #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sin,
  input  logic       sin_valid,
  input  logic       sof,
  input  logic       out_ready,
  output logic       out0,
  output logic       out1,
  output logic       out2,
  output logic       out3,
  output logic       out4,
  output logic       out5,
  output logic       out6,
  output logic       out7,
  output logic       out_valid,
  output logic [2:0] slot,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned WORD_W = 8;
  localparam int unsigned SLOT_W = 3;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(WORD_W - 1);
  localparam logic [SLOT_W-1:0] FIRST_IDX = MSB_FIRST ? LAST_SLOT : '0;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [WORD_W-1:0]   shadow_q, shadow_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                out_valid_q, out_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;
  logic [SLOT_W-1:0]   idx;
  logic [WORD_W-1:0]   full_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      shadow_q    <= '0;
      word_q      <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      shadow_q    <= shadow_d;
      word_q      <= word_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state: handshake clear first so a completing word overrides it.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    shadow_d    = shadow_q;
    word_d      = word_q;
    out_valid_d = out_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    idx         = MSB_FIRST ? SLOT_W'(LAST_SLOT - slot_q) : slot_q;
    full_word   = shadow_q;
    full_word[idx] = sin;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (sin_valid) begin
      if (state_q == IDLE) begin
        if (sof) begin
          shadow_d            = '0;
          shadow_d[FIRST_IDX] = sin;
          slot_d              = SLOT_W'(1);
          state_d             = COLLECT;
        end
      end else if (sof && (slot_q != '0)) begin
        // Resync: drop the partial word and restart at slot 0.
        shadow_d            = '0;
        shadow_d[FIRST_IDX] = sin;
        slot_d              = SLOT_W'(1);
        frame_err_d         = 1'b1;
      end else begin
        shadow_d[idx] = sin;
        slot_d        = SLOT_W'(slot_q + SLOT_W'(1));
        if (slot_q == LAST_SLOT) begin
          if (!out_valid_q || out_ready) begin
            word_d      = full_word;
            out_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
    end
  end

  assign out0      = word_q[0];
  assign out1      = word_q[1];
  assign out2      = word_q[2];
  assign out3      = word_q[3];
  assign out4      = word_q[4];
  assign out5      = word_q[5];
  assign out6      = word_q[6];
  assign out7      = word_q[7];
  assign out_valid = out_valid_q;
  assign slot      = slot_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_deser_1to8.sv
// Directed bench for deser_1to8: LSB-first and MSB-first instances share stimulus.
module tb_deser_1to8;

  logic clk = 1'b0;
  logic rst, sin, sin_valid, sof, out_ready;

  logic l0, l1, l2, l3, l4, l5, l6, l7, l_valid, l_ferr, l_ovr;
  logic m0, m1, m2, m3, m4, m5, m6, m7, m_valid, m_ferr, m_ovr;
  logic [2:0] l_slot, m_slot;
  logic [7:0] l_word, m_word;

  int checks = 0;
  int errors = 0;

  assign l_word = {l7, l6, l5, l4, l3, l2, l1, l0};
  assign m_word = {m7, m6, m5, m4, m3, m2, m1, m0};

  always #5 clk = ~clk;

  deser_1to8 #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .out_ready(out_ready),
    .out0(l0), .out1(l1), .out2(l2), .out3(l3),
    .out4(l4), .out5(l5), .out6(l6), .out7(l7),
    .out_valid(l_valid), .slot(l_slot), .frame_err(l_ferr), .overrun(l_ovr)
  );

  deser_1to8 #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .out_ready(out_ready),
    .out0(m0), .out1(m1), .out2(m2), .out3(m3),
    .out4(m4), .out5(m5), .out6(m6), .out7(m7),
    .out_valid(m_valid), .slot(m_slot), .frame_err(m_ferr), .overrun(m_ovr)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one qualified bit for exactly one edge; returns 1 time unit after it.
  task automatic send_bit(input logic s, input logic b);
    sin_valid = 1'b1;
    sof       = s;
    sin       = b;
    @(posedge clk);
    #1;
    sin_valid = 1'b0;
    sof       = 1'b0;
    sin       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  // Sends vec bit 0 first; optional sof on the first bit and idle gaps between bits.
  task automatic send_frame(input logic [7:0] vec, input logic first_sof, input int gap);
    for (int i = 0; i < 8; i++) begin
      send_bit(first_sof && (i == 0), vec[i]);
      if (i != 7) idle(gap);
    end
  endtask

  initial begin
    logic [7:0] v;
    rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; sof = 1'b0; out_ready = 1'b1;
    idle(2);
    chk("rst_word", l_word, 8'h00);
    chk("rst_valid", {7'd0, l_valid}, 8'd0);
    chk("rst_slot", {5'd0, l_slot}, 8'd0);
    chk("rst_ferr", {7'd0, l_ferr}, 8'd0);
    chk("rst_ovr", {7'd0, l_ovr}, 8'd0);
    chk("rst_m_status", {m_valid, m_ferr, m_ovr, m_slot}, 8'd0);
    rst = 1'b0;

    // Stream 1,0,1,1,0,0,1,0 on consecutive edges.
    v = 8'h4D;
    for (int i = 0; i < 7; i++) send_bit(i == 0, v[i]);
    chk("t1_valid_pre", {7'd0, l_valid}, 8'd0);
    chk("t1_slot7", {5'd0, l_slot}, 8'd7);
    send_bit(1'b0, v[7]);
    chk("t1_word", l_word, 8'h4D);
    chk("t1_valid", {7'd0, l_valid}, 8'd1);
    chk("t1_slot0", {5'd0, l_slot}, 8'd0);
    chk("t1_msb_word", m_word, 8'hB2);
    idle(1);
    chk("t1_valid_clr", {7'd0, l_valid}, 8'd0);
    chk("t1_word_hold", l_word, 8'h4D);

    // No sof in IDLE: bits are ignored.
    pulse_reset();
    for (int i = 0; i < 10; i++) send_bit(1'b0, 1'b1);
    chk("t3_idle_slot", {5'd0, l_slot}, 8'd0);
    chk("t3_idle_valid", {7'd0, l_valid}, 8'd0);
    send_bit(1'b1, 1'b0);
    idle(3);
    chk("t3_gap_slot", {5'd0, l_slot}, 8'd1);
    send_bit(1'b0, 1'b1);
    for (int i = 2; i < 8; i++) begin
      idle(3);
      send_bit(1'b0, 8'h96 >> i);
    end
    chk("t3_word", l_word, 8'h96);
    chk("t3_valid", {7'd0, l_valid}, 8'd1);
    chk("t3_msb_word", m_word, 8'h69);

    // Backpressure: second word dropped, third accepted on the completion edge.
    pulse_reset();
    out_ready = 1'b0;
    send_frame(8'hA5, 1'b1, 0);
    chk("t4_a5_word", l_word, 8'hA5);
    chk("t4_a5_ovr", {7'd0, l_ovr}, 8'd0);
    send_frame(8'h3C, 1'b0, 0);
    chk("t4_hold_word", l_word, 8'hA5);
    chk("t4_hold_valid", {7'd0, l_valid}, 8'd1);
    chk("t4_ovr", {7'd0, l_ovr}, 8'd1);
    v = 8'h0F;
    for (int i = 0; i < 7; i++) send_bit(1'b0, v[i]);
    out_ready = 1'b1;
    send_bit(1'b0, v[7]);
    chk("t4_0f_word", l_word, 8'h0F);
    chk("t4_0f_valid", {7'd0, l_valid}, 8'd1);
    chk("t4_ovr_sticky", {7'd0, l_ovr}, 8'd1);
    chk("t4_msb_word", m_word, 8'hF0);

    // Resync at slot 5.
    idle(1);
    chk("t5_valid_clr", {7'd0, l_valid}, 8'd0);
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1);
    chk("t5_slot5", {5'd0, l_slot}, 8'd5);
    chk("t5_ferr_pre", {7'd0, l_ferr}, 8'd0);
    send_bit(1'b1, 1'b1);
    chk("t5_ferr", {7'd0, l_ferr}, 8'd1);
    chk("t5_slot1", {5'd0, l_slot}, 8'd1);
    idle(1);
    chk("t5_ferr_clr", {7'd0, l_ferr}, 8'd0);
    v = 8'h81;
    for (int i = 1; i < 8; i++) send_bit(1'b0, v[i]);
    chk("t5_word", l_word, 8'h81);
    chk("t5_valid", {7'd0, l_valid}, 8'd1);
    chk("t5_msb_word", m_word, 8'h81);

    // Async reset mid-frame with an unconsumed word.
    out_ready = 1'b0;
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1);
    chk("t6_slot4", {5'd0, l_slot}, 8'd4);
    chk("t6_valid", {7'd0, l_valid}, 8'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_word", l_word, 8'h00);
    chk("t6_rst_status", {l_valid, l_ferr, l_ovr, l_slot}, 8'd0);
    chk("t6_rst_m_status", {m_valid, m_ferr, m_ovr, m_slot}, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b1);
    chk("t6_post_slot", {5'd0, l_slot}, 8'd0);
    chk("t6_post_valid", {7'd0, l_valid}, 8'd0);
    chk("t6_post_word", l_word, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/deser_1to8.md
Name: deser_1to8

Overview:
- Serial-to-parallel receiver: the other end of the 8-to-1 selection path.
- Takes one bit per qualified clock and steers it into one of 8 slots using an internal 3-bit slot counter (the receive-side counterpart of sel).
- Presents the completed 8-bit word on eight 1-bit outputs out0..out7 with a valid/ready handshake.
- Sits downstream of the 8-to-1 mux transmit path in the bit-serial link datapath.

Parameters:
- MSB_FIRST, 0, 0: first bit of a frame lands in out0 (slot 0 ↔ sel 3'b000). 1: first bit lands in out7.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is sampled on this edge when high.
- sof  input  1  start-of-frame; qualified by sin_valid; marks sin as slot-0 bit.
- out_ready  input  1  consumer accepts the presented word.
- out0..out7  output  1 each  parallel word bits (eight separate ports).
- out_valid  output  1  out0..out7 hold an unconsumed word.
- slot  output  3  next slot to be written (current counter value).
- frame_err  output  1  one-cycle pulse on resynchronisation.
- overrun  output  1  sticky; a completed word was dropped.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, slot=0, shadow=0, out0..out7=0, out_valid=0, frame_err=0, overrun=0.
  - Deassertion is not required to be synchronised inside the block.
- Slot mapping:
  - bit written to shadow[idx], where idx = slot if MSB_FIRST=0, else 7-slot.
  - slot increments mod 8 (7 → 0 wrap) on each accepted bit.
- State IDLE:
  - sin_valid=0, or sin_valid=1 with sof=0: no change.
  - sof alone without sin_valid: ignored.
  - sin_valid=1 & sof=1: write bit to slot 0, slot←1, go COLLECT.
- State COLLECT:
  - sin_valid=0: hold; gaps of any length allowed.
  - sin_valid=1, sof=0: write bit to shadow, slot increments.
  - sin_valid=1, sof=1, slot≠0 (resync): discard partial word, write bit to slot 0, slot←1, frame_err=1 for exactly one cycle.
  - sin_valid=1, sof=1, slot=0: normal frame start, no error.
- Word completion (bit accepted with slot=7):
  - Full word = shadow plus the current bit.
  - If out_valid=0, or (out_valid=1 & out_ready=1) on the same edge: load out0..out7, out_valid=1 after that edge.
  - Latency: the 8th bit sampled at edge k is visible on out0..out7 after edge k.
  - Else: word dropped, outputs unchanged, overrun←1 (sticky until rst).
  - In both cases slot wraps to 0 and the state stays COLLECT, so back-to-back frames need no sof; sof on the next slot-0 bit is legal.
- Output handshake:
  - out_valid & out_ready on an edge with no new word: out_valid←0; out0..out7 keep their values (not cleared).
  - out0..out7 are stable while out_valid=1.
- Simultaneous events: completion, handshake and resync on one edge are resolved per the rules above; completion takes priority over clearing out_valid.
- rst mid-frame: partial word is lost; the next frame requires sof.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- MSB_FIRST=0, out_ready=1: sof with bits 1,0,1,1,0,0,1,0 on consecutive edges → out0..out7=1,0,1,1,0,0,1,0; out_valid high exactly one cycle after the 8th edge; slot returns to 0.
- MSB_FIRST=1, same stream → out7..out0=1,0,1,1,0,0,1,0.
- sin_valid without sof in IDLE for 10 cycles → slot stays 0, out_valid stays 0. Then a sof frame with idle gaps of 3 cycles between bits → correct word.
- out_ready=0: two complete frames 0xA5 then 0x3C (LSB-first) → outputs hold 0xA5 and overrun=1. Raise out_ready on the completion edge of a third frame 0x0F → 0x0F is loaded and overrun stays 1.
- sof reasserted when slot=5 → frame_err pulses one cycle, slot=1. The following 7 bits complete a new word; no stale bits appear.
- Assert rst asynchronously when slot=4 with out_valid=1 → all outputs 0 immediately. After release, bits without sof are ignored.
